// File: rtl/regfile_dump.sv
// Debug reader for the CPU register file: walks [first_addr..last_addr] on a spare
// read port, one register per beat, and streams {addr, data} out over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; raddr parked on the last index used
// READ  | raddr=idx, capture rdata into the output payload
// SEND  | beat presented, held until out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = first_addr;
          last_d  = last_addr;
          state_d = (first_addr > last_addr) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        out_data_d  = rdata;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          // compare before increment so last=31 terminates without wrapping
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_READ) || (state_q == S_SEND);
    done = (state_q == S_DONE);
  end

  assign raddr     = idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and randomized dumps.
module tb_regfile_dump;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] regs [32];
  assign rdata = regs[raddr];

  regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is the list of addresses still to be read; each
  // register is read one cycle after start or after the previous beat is taken.
  bit          m_active, m_read_next, m_valid, m_done;
  logic [4:0]  m_addr, m_raddr;
  logic [31:0] m_data;
  int          m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_read_next = 0; m_valid = 0; m_done = 0;
      m_addr = '0; m_raddr = '0; m_data = '0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_raddr = first_addr;
        m_q.delete();
        for (int a = int'(first_addr); a <= int'(last_addr); a++) m_q.push_back(a);
        if (m_q.size() == 0) m_done = 1;
        else begin m_active = 1; m_read_next = 1; end
      end
    end else if (m_read_next) begin
      m_addr = 5'(m_q.pop_front());
      m_data = regs[m_addr];
      m_valid = 1; m_read_next = 0;
    end else if (out_ready) begin
      m_valid = 0;
      if (m_q.size() == 0) begin m_active = 0; m_done = 1; end
      else begin m_raddr = 5'(m_q[0]); m_read_next = 1; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("raddr", {27'b0, raddr}, {27'b0, m_raddr});
      if (m_valid) begin
        chk("out_addr", {27'b0, out_addr}, {27'b0, m_addr});
        chk("out_data", out_data, m_data);
      end
    end
  end

  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      log_addr.push_back(out_addr);
      log_data.push_back(out_data);
    end
    if (rst_n && done) done_cnt++;
  end

  // 0: always ready, 1: ~30% random, 3: stall on beat 7
  int ready_mode = 0;
  bit rand_wr = 0;

  always @(negedge clk) begin
    case (ready_mode)
      1:       out_ready = ($urandom_range(0, 9) < 3);
      3:       out_ready = !(out_valid && out_addr == 5'd7);
      default: out_ready = 1'b1;
    endcase
    if (rand_wr && $urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = $urandom;
  end

  task automatic start_dump(input int f, input int l);
    @(negedge clk);
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, done_cnt > prev}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, f, l, exp_n;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_raddr", {27'b0, raddr}, 32'd0);
    chk("rst_out_addr", {27'b0, out_addr}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;

    // full range, always ready
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    start_dump(0, 31);
    wait_done(d0, "t1_done_seen");
    repeat (3) @(negedge clk);
    chk("t1_beats", log_addr.size(), 32'd32);
    for (int i = 0; i < 32 && i < log_addr.size(); i++) begin
      chk("t1_addr", {27'b0, log_addr[i]}, 32'(i));
      chk("t1_data", log_data[i], 32'(i) * 32'h11111111);
    end
    chk("t1_done_cnt", done_cnt - d0, 32'd1);
    chk("t1_busy_after", {31'b0, busy}, 32'd0);

    // single register
    regs[5] = 32'hDEADBEEF;
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    start_dump(5, 5);
    wait_done(d0, "t2_done_seen");
    chk("t2_beats", log_addr.size(), 32'd1);
    if (log_addr.size() > 0) begin
      chk("t2_addr", {27'b0, log_addr[0]}, 32'd5);
      chk("t2_data", log_data[0], 32'hDEADBEEF);
    end

    // empty range
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    @(negedge clk);
    first_addr = 5'd10; last_addr = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_done_pulse", {31'b0, done}, 32'd1);
    chk("t3_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_beats", log_addr.size(), 32'd0);
    chk("t3_done_cnt", done_cnt - d0, 32'd1);

    // backpressure with a write to r2 after its read
    ready_mode = 1;
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    start_dump(0, 3);
    n = 0;
    while (!(out_valid && out_addr == 5'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_r2_beat_seen", {31'b0, out_valid && out_addr == 5'd2}, 32'd1);
    regs[2] = 32'hCAFEF00D;
    wait_done(d0, "t4_done_seen");
    ready_mode = 0;
    chk("t4_beats", log_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      chk("t4_addr", {27'b0, log_addr[i]}, 32'(i));
    if (log_data.size() > 2) chk("t4_r2_old", log_data[2], 32'h22222222);

    // start while busy is ignored
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    start_dump(28, 31);
    repeat (2) @(negedge clk);
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, "t5_done_seen");
    repeat (5) @(negedge clk);
    chk("t5_beats", log_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      chk("t5_addr", {27'b0, log_addr[i]}, 32'(28 + i));
    chk("t5_done_cnt", done_cnt - d0, 32'd1);

    // reset mid-dump while beat 7 is stalled
    ready_mode = 3;
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    start_dump(0, 31);
    n = 0;
    while (!(out_valid && out_addr == 5'd7) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_beat7_seen", {31'b0, out_valid && out_addr == 5'd7}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_raddr", {27'b0, raddr}, 32'd0);
    chk("t6_rst_out_addr", {27'b0, out_addr}, 32'd0);
    chk("t6_rst_out_data", out_data, 32'd0);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 32'd0);
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    start_dump(4, 6);
    wait_done(d0, "t6_restart_done");
    chk("t6_restart_beats", log_addr.size(), 32'd3);
    if (log_addr.size() > 0) chk("t6_restart_first", {27'b0, log_addr[0]}, 32'd4);

    // randomized ranges with random backpressure and background regfile writes
    rand_wr = 1;
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      f = $urandom_range(0, 31);
      l = (k % 3 == 0) ? $urandom_range(0, 31) : $urandom_range(f, 31);
      exp_n = (f <= l) ? l - f + 1 : 0;
      log_addr.delete(); log_data.delete(); d0 = done_cnt;
      start_dump(f, l);
      wait_done(d0, "rnd_done_seen");
      repeat (2) @(negedge clk);
      chk("rnd_beats", log_addr.size(), 32'(exp_n));
      if (log_addr.size() > 0) chk("rnd_first_addr", {27'b0, log_addr[0]}, 32'(f));
    end
    rand_wr = 0;
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
